// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, the default bit timing, and
// frame-length helpers used by both uart_tx and the future uart_rx.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam int START_BITS = 1;

  // Bit periods in one frame: start + data + optional parity + stop bits
  function automatic int frameBits(input int dataWidth, input int parityEn, input int stopBits);
    return START_BITS + dataWidth + parityEn + stopBits;
  endfunction

  // Clock cycles from the first start-bit cycle to the return to idle
  function automatic int frameClks(input int dataWidth, input int parityEn, input int stopBits,
                                   input int clksPerBit);
    return frameBits(dataWidth, parityEn, stopBits) * clksPerBit;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider. Counts 0..P_CLKS_PER_BIT-1 while enabled and wraps;
// oBitDone marks the last cycle of each bit period. iClr holds it at zero
// so the first period after a clear is a full one.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int P_CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  output logic oBitDone
);

  localparam int CW = (P_CLKS_PER_BIT > 2) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Divider: clear dominates, wrap at the terminal count
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iEn) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign oBitDone = iEn && !iClr && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a show-ahead FIFO, one word per frame.
//
//   state  | meaning
//   IDLE   | line high, waiting for a non-empty FIFO
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | 1 or 2 stop bits (high)
//
// All outputs are flops; the word and its parity are captured on the pop
// edge, so later FIFO data changes never reach the current frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_DATA_WIDTH   = 8,
  parameter int P_CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int P_PARITY_EN    = 0,
  parameter int P_PARITY_ODD   = 0,
  parameter int P_STOP_BITS    = 1
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iFifoEmpty,
  input  logic [P_DATA_WIDTH-1:0] iFifoData,
  output logic                    oFifoPop,
  output logic                    oTx,
  output logic                    oBusy
);

  localparam int BW = $clog2(P_DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(P_DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(P_STOP_BITS - 1);

  logic [2:0]              state;
  logic [P_DATA_WIDTH-1:0] shiftReg;
  logic [BW-1:0]           bitCnt;
  logic                    parityBit;
  logic                    bitDone;

  uart_baud_cnt #(
    .P_CLKS_PER_BIT(P_CLKS_PER_BIT)
  ) uBaudCnt (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (state != ST_IDLE),
    .iClr    (state == ST_IDLE),
    .oBitDone(bitDone)
  );

  // Frame sequencer; bitCnt counts data bits in DATA and stop bits in STOP
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= ST_IDLE;
      oTx       <= 1'b1;
      oFifoPop  <= 1'b0;
      oBusy     <= 1'b0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
    end else begin
      oFifoPop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!iFifoEmpty) begin
            shiftReg  <= iFifoData;
            parityBit <= (^iFifoData) ^ (P_PARITY_ODD != 0);
            oFifoPop  <= 1'b1;
            oTx       <= 1'b0;
            oBusy     <= 1'b1;
            bitCnt    <= '0;
            state     <= ST_START;
          end else begin
            oTx <= 1'b1;
          end
        end
        ST_START: begin
          if (bitDone) begin
            oTx      <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bitDone) begin
            if (bitCnt == LAST_DATA) begin
              bitCnt <= '0;
              if (P_PARITY_EN != 0) begin
                oTx   <= parityBit;
                state <= ST_PARITY;
              end else begin
                oTx   <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              oTx      <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitCnt   <= bitCnt + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bitDone) begin
            oTx   <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bitDone) begin
            if (bitCnt == LAST_STOP) begin
              bitCnt <= '0;
              oBusy  <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              bitCnt <= bitCnt + BW'(1);
            end
          end
        end
        default: begin
          oTx   <= 1'b1;
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Four instances share clock and reset:
// 0 = 8N1, 1 = even parity, 2 = odd parity, 3 = two stop bits, all at
// 4 clocks per bit. Each drains its own small FIFO model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int P    = 4;
  localparam int NLOG = 200;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic [3:0] empty;
  logic [7:0] data [4];
  logic [3:0] pop;
  logic [3:0] tx;
  logic [3:0] busy;

  logic [7:0] mem [4][16];
  int         wr [4];
  int         rd [4];

  logic txLog [4][NLOG];
  logic busyLog [4][NLOG];
  logic popLog [4][NLOG];
  logic expTx [NLOG];
  logic expBusy [NLOG];
  logic expPop [NLOG];
  logic [7:0] fb [3];
  logic [7:0] decoded [4];
  int nDec;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  // Show-ahead FIFO models
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i] = (wr[i] == rd[i]);
      data[i]  = mem[i][rd[i][3:0]];
    end
  end

  // FIFO read pointers advance on the pop
  always @(posedge iClk) begin
    for (int i = 0; i < 4; i++)
      if (pop[i]) rd[i] <= rd[i] + 1;
  end

  uart_tx #(.P_CLKS_PER_BIT(P)) dut0 (
    .iClk(iClk), .iRst(iRst), .iFifoEmpty(empty[0]), .iFifoData(data[0]),
    .oFifoPop(pop[0]), .oTx(tx[0]), .oBusy(busy[0]));
  uart_tx #(.P_CLKS_PER_BIT(P), .P_PARITY_EN(1), .P_PARITY_ODD(0)) dut1 (
    .iClk(iClk), .iRst(iRst), .iFifoEmpty(empty[1]), .iFifoData(data[1]),
    .oFifoPop(pop[1]), .oTx(tx[1]), .oBusy(busy[1]));
  uart_tx #(.P_CLKS_PER_BIT(P), .P_PARITY_EN(1), .P_PARITY_ODD(1)) dut2 (
    .iClk(iClk), .iRst(iRst), .iFifoEmpty(empty[2]), .iFifoData(data[2]),
    .oFifoPop(pop[2]), .oTx(tx[2]), .oBusy(busy[2]));
  uart_tx #(.P_CLKS_PER_BIT(P), .P_STOP_BITS(2)) dut3 (
    .iClk(iClk), .iRst(iRst), .iFifoEmpty(empty[3]), .iFifoData(data[3]),
    .oFifoPop(pop[3]), .oTx(tx[3]), .oBusy(busy[3]));

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkVal(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    mem[d][wr[d][3:0]] = v;
    wr[d] = wr[d] + 1;
  endtask

  // Record all instances at each falling edge
  task automatic capture(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge iClk);
      for (int i = 0; i < 4; i++) begin
        txLog[i][s]   = tx[i];
        busyLog[i][s] = busy[i];
        popLog[i][s]  = pop[i];
      end
    end
  endtask

  // Reference waveform: frames from fb[] back to back, one idle cycle apart
  task automatic buildExp(input int nFrames, input int par, input int odd, input int stops,
                          input int n);
    int len, per, k, o, b;
    len = frameClks(8, par, stops, P);
    per = len + 1;
    for (int s = 0; s < n; s++) begin
      k = s / per;
      o = s % per;
      expTx[s] = 1'b1;
      expBusy[s] = 1'b0;
      expPop[s] = 1'b0;
      if (k < nFrames && o < len) begin
        b = o / P;
        expBusy[s] = 1'b1;
        expPop[s] = (o == 0);
        if (b == 0) expTx[s] = 1'b0;
        else if (b <= 8) expTx[s] = fb[k][b-1];
        else if (par != 0 && b == 9) expTx[s] = (^fb[k]) ^ odd[0];
      end
    end
  endtask

  task automatic cmpLog(input string tag, input int d, input int n);
    for (int s = 0; s < n; s++) begin
      chkBit($sformatf("%s tx[%0d]", tag, s), txLog[d][s], expTx[s]);
      chkBit($sformatf("%s busy[%0d]", tag, s), busyLog[d][s], expBusy[s]);
      chkBit($sformatf("%s pop[%0d]", tag, s), popLog[d][s], expPop[s]);
    end
  endtask

  function automatic int popCount(input int d, input int n);
    int c = 0;
    for (int s = 0; s < n; s++) if (popLog[d][s] === 1'b1) c++;
    return c;
  endfunction

  function automatic int busyCount(input int d, input int n);
    int c = 0;
    for (int s = 0; s < n; s++) if (busyLog[d][s] === 1'b1) c++;
    return c;
  endfunction

  function automatic int highRun(input int d, input int from, input int n);
    int c = 0;
    for (int s = from; s < n; s++) begin
      if (txLog[d][s] !== 1'b1) break;
      c++;
    end
    return c;
  endfunction

  // Simple 8N1 receiver on the instance-0 log: find start, sample mid-bit
  task automatic decode(input int n);
    int s;
    logic [7:0] by;
    s = 0;
    nDec = 0;
    while (s < n && nDec < 4) begin
      if (txLog[0][s] === 1'b0) begin
        if (s + 9 * P + P / 2 >= n) break;
        for (int i = 0; i < 8; i++) by[i] = txLog[0][s + (1 + i) * P + P / 2];
        decoded[nDec] = by;
        nDec++;
        s = s + 10 * P;
      end else begin
        s++;
      end
    end
  endtask

  initial begin
    int consec;

    // Reset values, applied asynchronously between clock edges
    #2 iRst = 1'b1;
    #1;
    chkBit("reset tx", tx[0], 1'b1);
    chkBit("reset busy", busy[0], 1'b0);
    chkBit("reset pop", pop[0], 1'b0);
    repeat (3) @(negedge iClk);
    iRst = 1'b0;

    // 1: single word 0xA5, 8N1
    fb[0] = 8'hA5;
    push(0, 8'hA5);
    capture(48);
    buildExp(1, 0, 0, 1, 48);
    cmpLog("t1", 0, 48);
    chkVal("t1 pops", popCount(0, 48), 1);
    chkVal("t1 busy cycles", busyCount(0, 48), 40);
    chkBit("t1 fifo empty", empty[0], 1'b1);
    decode(48);
    chkVal("t1 frames", nDec, 1);
    chkVal("t1 byte", int'(decoded[0]), 32'hA5);

    // 2: burst of three words
    fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'h3C;
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    capture(130);
    buildExp(3, 0, 0, 1, 130);
    cmpLog("t2", 0, 130);
    chkVal("t2 pops", popCount(0, 130), 3);
    consec = 0;
    for (int s = 0; s < 129; s++) if (popLog[0][s] === 1'b1 && popLog[0][s+1] === 1'b1) consec++;
    chkVal("t2 consecutive pops", consec, 0);
    chkVal("t2 idle gap", highRun(0, 36, 130), 5);
    decode(130);
    chkVal("t2 frames", nDec, 3);
    chkVal("t2 byte0", int'(decoded[0]), 32'h00);
    chkVal("t2 byte1", int'(decoded[1]), 32'hFF);
    chkVal("t2 byte2", int'(decoded[2]), 32'h3C);

    // 3: parity, even and odd, 0x07
    fb[0] = 8'h07;
    push(1, 8'h07);
    push(2, 8'h07);
    capture(50);
    buildExp(1, 1, 0, 1, 50);
    cmpLog("t3 even", 1, 50);
    buildExp(1, 1, 1, 1, 50);
    cmpLog("t3 odd", 2, 50);
    chkBit("t3 even parity bit", txLog[1][38], 1'b1);
    chkBit("t3 odd parity bit", txLog[2][38], 1'b0);
    chkVal("t3 frame length", busyCount(1, 50), 44);

    // 4: two stop bits, 0x55 twice
    fb[0] = 8'h55; fb[1] = 8'h55;
    push(3, 8'h55); push(3, 8'h55);
    capture(100);
    buildExp(2, 0, 0, 2, 100);
    cmpLog("t4", 3, 100);
    chkVal("t4 stop+idle high", highRun(3, 36, 100), 9);
    chkBit("t4 next start", txLog[3][45], 1'b0);

    // 5: reset during data bit 3 of 0xC3, then a clean 0x81
    push(0, 8'hC3);
    capture(18);
    chkBit("t5 mid-frame tx", tx[0], 1'b0);
    chkBit("t5 mid-frame busy", busy[0], 1'b1);
    #1 iRst = 1'b1;
    #1;
    chkBit("t5 reset tx", tx[0], 1'b1);
    chkBit("t5 reset busy", busy[0], 1'b0);
    chkBit("t5 reset pop", pop[0], 1'b0);
    push(0, 8'h81);
    @(negedge iClk);
    iRst = 1'b0;
    fb[0] = 8'h81;
    capture(48);
    buildExp(1, 0, 0, 1, 48);
    cmpLog("t5", 0, 48);
    decode(48);
    chkVal("t5 byte", int'(decoded[0]), 32'h81);

    // 6: empty FIFO, line must stay idle
    capture(200);
    buildExp(0, 0, 0, 1, 200);
    cmpLog("t6", 0, 200);
    chkVal("t6 pops", popCount(0, 200), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that sits directly downstream of the TX-side Fifo instance.
- Drains the FIFO one word per frame using a show-ahead read: data at the read pointer is valid whenever the FIFO is not empty, and the transmitter issues a one-cycle pop.
- Serialises each word as 8N1, with optional parity and 1 or 2 stop bits, onto the TX pin.
- Bit timing comes from an internal clock divider. No external baud tick is used.

Parameters:
- P_DATA_WIDTH, 8, data bits per frame; must match the FIFO data width.
- P_CLKS_PER_BIT, 868, iClk cycles per bit (100 MHz / 115200); legal range ≥ 2.
- P_PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- P_PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when P_PARITY_EN = 0.
- P_STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous, active-high reset.
- iFifoEmpty  in  1  FIFO oEmpty.
- iFifoData  in  P_DATA_WIDTH  FIFO oPopData (show-ahead).
- oFifoPop  out  1  FIFO iPop; registered, single-cycle pulse.
- oTx  out  1  serial line; idle high; registered.
- oBusy  out  1  high from the start bit through the last stop bit.

Behaviour:
- Reset (async, iRst = 1): state = IDLE, oTx = 1, oFifoPop = 0, oBusy = 0, bit counter = 0, divider = 0, shift register = 0. Reset mid-frame aborts the frame immediately (oTx = 1 from the reset assertion). The FIFO word already popped is lost.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if iFifoEmpty = 0 at edge t:
    - latch iFifoData into the shift register;
    - set the parity accumulator to XOR of the data, XOR P_PARITY_ODD;
    - oFifoPop = 1 for cycle t+1 only;
    - oTx = 0 and oBusy = 1 from t+1;
    - go to START.
  - If iFifoEmpty = 1 in IDLE, hold with oTx = 1.
  - Each of START, DATA, PARITY, STOP holds for exactly P_CLKS_PER_BIT cycles per bit. The divider counts 0..P_CLKS_PER_BIT-1 and wraps at the bit boundary.
  - START → DATA: shift the register out LSB first, one bit per bit period. After bit P_DATA_WIDTH-1, go to PARITY if P_PARITY_EN = 1, else STOP.
  - PARITY: one bit period; oTx = parity bit.
  - STOP: oTx = 1 for P_STOP_BITS bit periods, then IDLE. oBusy falls on entry to IDLE.
- Frame length from the first start-bit cycle to the IDLE entry = (1 + P_DATA_WIDTH + P_PARITY_EN + P_STOP_BITS) × P_CLKS_PER_BIT cycles.
- Back-to-back frames: IDLE lasts at least 1 cycle, so the inter-frame idle-high time = stop duration + exactly 1 clock.
- Pop rule:
  - Exactly one pop per frame.
  - oFifoPop is never asserted while iFifoEmpty = 1 was the sampled condition.
  - oFifoPop is never asserted in two consecutive cycles.
  - The FIFO count drops at edge t+2. The FSM is in START by then, so there is no double pop.
- iFifoData changes after the latch edge have no effect on the current frame.
- Divider and bit-counter widths: $clog2(P_CLKS_PER_BIT) and $clog2(P_DATA_WIDTH+1). No overflow is permitted; both saturate only at their terminal counts.
- All outputs come directly from flops. There is no combinational path from iFifoEmpty or iFifoData to any output.

Decomposition:
- Shared package holds:
  - the state encodings (3-bit: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4);
  - the default clocks-per-bit constant (868);
  - frame-length helper constants, shared with the future uart_rx.
- One natural sub-module: uart_baud_cnt. It is the divider with an enable/clear input and a single-cycle oBitDone pulse at count P_CLKS_PER_BIT-1, and is reusable by uart_rx.

Test Plan:
All cases use P_CLKS_PER_BIT = 4 unless noted.

1. Single word, 8N1: push 0xA5 into an empty FIFO. Required response:
   - exactly one oFifoPop pulse;
   - oTx = 0 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles;
   - oBusy high for 40 cycles; FIFO empty afterwards.
2. Burst: push 0x00, 0xFF, 0x3C back-to-back. Required response:
   - three frames, in order, decoded by the bench receiver;
   - exactly 3 pops;
   - idle gap between frames = 4 + 1 cycles;
   - oFifoPop never asserted in consecutive cycles.
3. Parity, P_PARITY_EN = 1:
   - 0x07 with even parity → parity bit 1;
   - 0x07 with P_PARITY_ODD = 1 → parity bit 0;
   - frame length 44 cycles.
4. Two stop bits, P_STOP_BITS = 2: send 0x55. Required response: oTx high for 8 cycles after the last data bit; next frame's start bit appears 1 cycle later.
5. Reset mid-frame: assert iRst during data bit 3 of 0xC3. Required response:
   - oTx = 1, oBusy = 0, oFifoPop = 0 asynchronously;
   - after release with the FIFO holding 0x81, the next frame is a clean 0x81 starting from a fresh start bit.
6. Empty FIFO idle: 200 cycles with iFifoEmpty = 1. Required response: oTx stays 1, oFifoPop stays 0, oBusy stays 0.
